pipeline_exa_stage5: RTL and testbench

- Execute-ALU stage of the 5-stage pipeline. Sits directly downstream of the execute-branch stage and upstream of the memory stage.
- Consumes the branch stage's registered *_EXB bundle, selects operands and computes the ALU result.
- Performs 64-bit MUL iteratively over multiple cycles, raising busy_EXA to hold the upstream pipeline.
- Registers the result and the pass-through control fields into the *_EXA bundle for the memory stage.

---
 rtl/pipeline_exa_stage5.sv | 200 ++++++++++++++++++++
 tb/tb_pipeline_exa_stage5.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_exa_stage5.sv
// Execute-ALU stage: operand select, single-cycle ALU, iterative 64-bit
// shift-add multiplier, and the registered *_EXA bundle for the memory stage.
module pipeline_exa_stage5 #(
  parameter int unsigned XLEN      = 64,
  parameter int unsigned MUL_STEPS = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            stall,
  input  logic [XLEN-1:0] pc_EXB,
  input  logic [XLEN-1:0] reg_data1_EXB,
  input  logic [XLEN-1:0] reg_data2_EXB,
  input  logic [XLEN-1:0] imm_EXB,
  input  logic [4:0]      rd_EXB,
  input  logic            rf_wr_en_EXB,
  input  logic [1:0]      rf_wr_sel_EXB,
  input  logic [3:0]      alu_ctrl_EXB,
  input  logic            alu_a_sel_EXB,
  input  logic            alu_b_sel_EXB,
  input  logic [2:0]      dm_rd_ctrl_EXB,
  input  logic [2:0]      dm_wr_ctrl_EXB,
  output logic            busy_EXA,
  output logic [XLEN-1:0] alu_result_EXA,
  output logic [XLEN-1:0] pc_EXA,
  output logic [XLEN-1:0] reg_data2_EXA,
  output logic [4:0]      rd_EXA,
  output logic            rf_wr_en_EXA,
  output logic [1:0]      rf_wr_sel_EXA,
  output logic [2:0]      dm_rd_ctrl_EXA,
  output logic [2:0]      dm_wr_ctrl_EXA
);

  localparam int unsigned CNT_W = (MUL_STEPS > 1) ? $clog2(MUL_STEPS) : 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(MUL_STEPS - 1);

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_SLL   = 4'd2;
  localparam logic [3:0] OP_SLT   = 4'd3;
  localparam logic [3:0] OP_SLTU  = 4'd4;
  localparam logic [3:0] OP_XOR   = 4'd5;
  localparam logic [3:0] OP_SRL   = 4'd6;
  localparam logic [3:0] OP_SRA   = 4'd7;
  localparam logic [3:0] OP_OR    = 4'd8;
  localparam logic [3:0] OP_AND   = 4'd9;
  localparam logic [3:0] OP_PASSB = 4'd10;
  localparam logic [3:0] OP_MUL   = 4'd11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, next_state;

  logic [XLEN-1:0]  op_a, op_b, alu_out;
  logic [5:0]       shamt;
  logic             lt_signed, lt_unsigned;

  logic [XLEN-1:0]  mul_a, mul_b, product;
  logic [CNT_W-1:0] cnt;

  logic mul_start, mul_step, out_load, out_clear, out_sel_prod;

  // Operand selection and single-cycle ALU
  always_comb begin
    op_a        = alu_a_sel_EXB ? pc_EXB  : reg_data1_EXB;
    op_b        = alu_b_sel_EXB ? imm_EXB : reg_data2_EXB;
    shamt       = op_b[5:0];
    lt_signed   = $signed(op_a) < $signed(op_b);
    lt_unsigned = op_a < op_b;
    case (alu_ctrl_EXB)
      OP_ADD:   alu_out = op_a + op_b;
      OP_SUB:   alu_out = op_a - op_b;
      OP_SLL:   alu_out = op_a << shamt;
      OP_SLT:   alu_out = {{(XLEN-1){1'b0}}, lt_signed};
      OP_SLTU:  alu_out = {{(XLEN-1){1'b0}}, lt_unsigned};
      OP_XOR:   alu_out = op_a ^ op_b;
      OP_SRL:   alu_out = op_a >> shamt;
      OP_SRA:   alu_out = $signed(op_a) >>> shamt;
      OP_OR:    alu_out = op_a | op_b;
      OP_AND:   alu_out = op_a & op_b;
      OP_PASSB: alu_out = op_b;
      default:  alu_out = op_a + op_b;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state, busy flag and datapath/output control
  always_comb begin
    next_state   = state;
    busy_EXA     = 1'b0;
    mul_start    = 1'b0;
    mul_step     = 1'b0;
    out_load     = 1'b0;
    out_clear    = 1'b0;
    out_sel_prod = 1'b0;
    case (state)
      IDLE: begin
        if (flush) begin
          out_clear = 1'b1;
        end else if (!stall) begin
          if (alu_ctrl_EXB == OP_MUL) begin
            // Busy is gated by reset so it reads 0 while the stage is held in reset
            busy_EXA   = reset;
            mul_start  = 1'b1;
            out_clear  = 1'b1;
            next_state = BUSY;
          end else begin
            out_load = 1'b1;
          end
        end
      end
      BUSY: begin
        busy_EXA = 1'b1;
        if (flush) begin
          out_clear  = 1'b1;
          next_state = IDLE;
        end else begin
          mul_step = 1'b1;
          if (cnt == LAST_STEP) next_state = DONE;
        end
      end
      DONE: begin
        if (flush) begin
          out_clear  = 1'b1;
          next_state = IDLE;
        end else if (!stall) begin
          out_load     = 1'b1;
          out_sel_prod = 1'b1;
          next_state   = IDLE;
        end
      end
      default: begin
        out_clear  = 1'b1;
        next_state = IDLE;
      end
    endcase
  end

  // Shift-add multiplier: one multiplier bit consumed per step
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mul_a   <= '0;
      mul_b   <= '0;
      product <= '0;
      cnt     <= '0;
    end else if (mul_start) begin
      mul_a   <= op_a;
      mul_b   <= op_b;
      product <= '0;
      cnt     <= '0;
    end else if (mul_step) begin
      if (mul_b[0]) product <= product + mul_a;
      mul_a <= mul_a << 1;
      mul_b <= mul_b >> 1;
      cnt   <= cnt + CNT_W'(1);
    end
  end

  // EXA output bundle: clear for bubbles/flush, load on issue, otherwise hold
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alu_result_EXA <= '0;
      pc_EXA         <= '0;
      reg_data2_EXA  <= '0;
      rd_EXA         <= '0;
      rf_wr_en_EXA   <= 1'b0;
      rf_wr_sel_EXA  <= '0;
      dm_rd_ctrl_EXA <= '0;
      dm_wr_ctrl_EXA <= '0;
    end else if (out_clear) begin
      alu_result_EXA <= '0;
      pc_EXA         <= '0;
      reg_data2_EXA  <= '0;
      rd_EXA         <= '0;
      rf_wr_en_EXA   <= 1'b0;
      rf_wr_sel_EXA  <= '0;
      dm_rd_ctrl_EXA <= '0;
      dm_wr_ctrl_EXA <= '0;
    end else if (out_load) begin
      alu_result_EXA <= out_sel_prod ? product : alu_out;
      pc_EXA         <= pc_EXB;
      reg_data2_EXA  <= reg_data2_EXB;
      rd_EXA         <= rd_EXB;
      rf_wr_en_EXA   <= rf_wr_en_EXB;
      rf_wr_sel_EXA  <= rf_wr_sel_EXB;
      dm_rd_ctrl_EXA <= dm_rd_ctrl_EXB;
      dm_wr_ctrl_EXA <= dm_wr_ctrl_EXB;
    end
  end

endmodule

// File: tb/tb_pipeline_exa_stage5.sv
// Scoreboard bench for pipeline_exa_stage5: a transaction-level model pushes
// the expected per-cycle view; a negedge monitor pops and compares.
module tb_pipeline_exa_stage5;

  logic        clk = 1'b1;
  logic        reset, flush, stall;
  logic [63:0] pc_EXB, reg_data1_EXB, reg_data2_EXB, imm_EXB;
  logic [4:0]  rd_EXB;
  logic        rf_wr_en_EXB;
  logic [1:0]  rf_wr_sel_EXB;
  logic [3:0]  alu_ctrl_EXB;
  logic        alu_a_sel_EXB, alu_b_sel_EXB;
  logic [2:0]  dm_rd_ctrl_EXB, dm_wr_ctrl_EXB;
  logic        busy_EXA;
  logic [63:0] alu_result_EXA, pc_EXA, reg_data2_EXA;
  logic [4:0]  rd_EXA;
  logic        rf_wr_en_EXA;
  logic [1:0]  rf_wr_sel_EXA;
  logic [2:0]  dm_rd_ctrl_EXA, dm_wr_ctrl_EXA;

  always #5 clk = ~clk;

  pipeline_exa_stage5 dut (
    .clk(clk), .reset(reset), .flush(flush), .stall(stall),
    .pc_EXB(pc_EXB), .reg_data1_EXB(reg_data1_EXB), .reg_data2_EXB(reg_data2_EXB),
    .imm_EXB(imm_EXB), .rd_EXB(rd_EXB), .rf_wr_en_EXB(rf_wr_en_EXB),
    .rf_wr_sel_EXB(rf_wr_sel_EXB), .alu_ctrl_EXB(alu_ctrl_EXB),
    .alu_a_sel_EXB(alu_a_sel_EXB), .alu_b_sel_EXB(alu_b_sel_EXB),
    .dm_rd_ctrl_EXB(dm_rd_ctrl_EXB), .dm_wr_ctrl_EXB(dm_wr_ctrl_EXB),
    .busy_EXA(busy_EXA), .alu_result_EXA(alu_result_EXA), .pc_EXA(pc_EXA),
    .reg_data2_EXA(reg_data2_EXA), .rd_EXA(rd_EXA), .rf_wr_en_EXA(rf_wr_en_EXA),
    .rf_wr_sel_EXA(rf_wr_sel_EXA), .dm_rd_ctrl_EXA(dm_rd_ctrl_EXA),
    .dm_wr_ctrl_EXA(dm_wr_ctrl_EXA)
  );

  typedef struct packed {
    logic [63:0] res;
    logic [63:0] pc;
    logic [63:0] rd2;
    logic [4:0]  rd;
    logic        we;
    logic [1:0]  ws;
    logic [2:0]  rc;
    logic [2:0]  wc;
  } out_t;

  typedef struct packed {
    logic busy;
    out_t out;
  } exp_t;

  typedef enum {M_IDLE, M_BUSY, M_DONE} mmode_t;

  mmode_t      m_mode = M_IDLE;
  int          m_left = 0;
  logic [63:0] m_prod = '0;
  out_t        m_out  = '0;
  exp_t        sb[$];
  int          checks = 0;
  int          passed = 0;

  // Reference ALU written from the arithmetic rules
  function automatic logic [63:0] ref_alu(input logic [3:0] op, input logic [63:0] a,
                                          input logic [63:0] b);
    int          sh;
    logic [63:0] ones, r;
    sh   = int'(b[5:0]);
    ones = '1;
    case (op)
      4'd1:  r = a - b;
      4'd2:  r = a << sh;
      4'd3:  r = (a[63] != b[63]) ? {63'd0, a[63]} : ((a < b) ? 64'd1 : 64'd0);
      4'd4:  r = (a < b) ? 64'd1 : 64'd0;
      4'd5:  r = a ^ b;
      4'd6:  r = a >> sh;
      4'd7:  begin r = a >> sh; if (a[63]) r = r | ~(ones >> sh); end
      4'd8:  r = a | b;
      4'd9:  r = a & b;
      4'd10: r = b;
      default: r = a + b;
    endcase
    return r;
  endfunction

  function automatic out_t bundle(input logic [63:0] res);
    out_t o;
    o.res = res; o.pc = pc_EXB; o.rd2 = reg_data2_EXB; o.rd = rd_EXB;
    o.we = rf_wr_en_EXB; o.ws = rf_wr_sel_EXB; o.rc = dm_rd_ctrl_EXB; o.wc = dm_wr_ctrl_EXB;
    return o;
  endfunction

  function automatic logic [63:0] sel_a();
    return alu_a_sel_EXB ? pc_EXB : reg_data1_EXB;
  endfunction

  function automatic logic [63:0] sel_b();
    return alu_b_sel_EXB ? imm_EXB : reg_data2_EXB;
  endfunction

  // Expected view of the cycle that has just been driven
  task automatic push_exp();
    exp_t e;
    if (!reset) begin
      m_out  = '0;
      m_mode = M_IDLE;
    end
    e.out  = m_out;
    e.busy = reset && (m_mode == M_BUSY ||
             (m_mode == M_IDLE && alu_ctrl_EXB == 4'd11 && !stall && !flush));
    sb.push_back(e);
  endtask

  // Advance the model across one clock edge using the inputs seen at that edge
  task automatic model_edge();
    if (!reset) return;
    if (flush) begin
      m_out  = '0;
      m_mode = M_IDLE;
      return;
    end
    case (m_mode)
      M_IDLE: if (!stall) begin
        if (alu_ctrl_EXB == 4'd11) begin
          m_prod = sel_a() * sel_b();
          m_left = 64;
          m_mode = M_BUSY;
          m_out  = '0;
        end else begin
          m_out = bundle(ref_alu(alu_ctrl_EXB, sel_a(), sel_b()));
        end
      end
      M_BUSY: begin
        m_left--;
        if (m_left == 0) m_mode = M_DONE;
      end
      M_DONE: if (!stall) begin
        m_out  = bundle(m_prod);
        m_mode = M_IDLE;
      end
      default: m_mode = M_IDLE;
    endcase
  endtask

  task automatic cyc();
    push_exp();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [63:0] d1, input logic [63:0] d2,
                       input logic asel, input logic bsel, input logic [63:0] pcv,
                       input logic [63:0] immv);
    alu_ctrl_EXB = op; reg_data1_EXB = d1; reg_data2_EXB = d2;
    alu_a_sel_EXB = asel; alu_b_sel_EXB = bsel; pc_EXB = pcv; imm_EXB = immv;
    rd_EXB = 5'($urandom); rf_wr_en_EXB = 1'($urandom); rf_wr_sel_EXB = 2'($urandom);
    dm_rd_ctrl_EXB = 3'($urandom); dm_wr_ctrl_EXB = 3'($urandom);
    stall = 1'b0; flush = 1'b0;
  endtask

  function automatic logic [63:0] rnd64();
    logic [63:0] v;
    v = {$urandom, $urandom};
    if ($urandom_range(0, 3) == 0) v = 64'($urandom_range(0, 20));
    return v;
  endfunction

  // Monitor: compare the presented stage outputs against the scoreboard each cycle
  always @(negedge clk) begin
    exp_t e;
    out_t got;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      got = '{alu_result_EXA, pc_EXA, reg_data2_EXA, rd_EXA, rf_wr_en_EXA,
              rf_wr_sel_EXA, dm_rd_ctrl_EXA, dm_wr_ctrl_EXA};
      checks++;
      if (busy_EXA === e.busy) passed++;
      else $display("FAIL busy_EXA t=%0t got=%b exp=%b", $time, busy_EXA, e.busy);
      checks++;
      if (got === e.out) passed++;
      else $display("FAIL exa_bundle t=%0t got res=%h pc=%h rd2=%h rd=%0d we=%b ws=%0d rc=%0d wc=%0d exp res=%h pc=%h rd2=%h rd=%0d we=%b ws=%0d rc=%0d wc=%0d",
                    $time, got.res, got.pc, got.rd2, got.rd, got.we, got.ws, got.rc, got.wc,
                    e.out.res, e.out.pc, e.out.rd2, e.out.rd, e.out.we, e.out.ws, e.out.rc, e.out.wc);
    end
  end

  initial begin
    // Reset held with random inputs, then released under stall
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(4'($urandom), rnd64(), rnd64(), 1'($urandom), 1'($urandom), rnd64(), rnd64());
      stall = 1'($urandom); flush = 1'($urandom);
      cyc();
    end
    reset = 1'b1;
    drive(4'd0, 64'd1, 64'd2, 1'b0, 1'b0, 64'h40, 64'h0);
    stall = 1'b1;
    cyc();

    // Directed ALU operations
    drive(4'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h100, 64'h0);   cyc();
    drive(4'd1, 64'd5, 64'd7, 1'b0, 1'b0, 64'h104, 64'h0);                      cyc();
    drive(4'd7, 64'h8000_0000_0000_0000, 64'd0, 1'b0, 1'b1, 64'h108, 64'd63);   cyc();
    drive(4'd4, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 64'h10C, 64'h0);    cyc();
    drive(4'd3, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 64'h110, 64'h0);    cyc();
    drive(4'd0, 64'd99, 64'd77, 1'b1, 1'b1, 64'h1000, 64'h20);                  cyc();

    // MUL -3 * 5 followed by an ADD
    drive(4'd11, 64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 1'b0, 1'b0, 64'h200, 64'h0);
    repeat (66) cyc();
    drive(4'd0, 64'd3, 64'd4, 1'b0, 1'b0, 64'h204, 64'h0);
    cyc(); cyc();

    // Flush at BUSY step 20, then MUL 7 * 6
    drive(4'd11, 64'd9, 64'd9, 1'b0, 1'b0, 64'h300, 64'h0);
    repeat (21) cyc();
    flush = 1'b1; cyc();
    drive(4'd0, 64'd1, 64'd1, 1'b0, 1'b0, 64'h304, 64'h0); cyc();
    drive(4'd11, 64'd7, 64'd6, 1'b0, 1'b0, 64'h308, 64'h0);
    repeat (66) cyc();
    drive(4'd9, 64'hF0, 64'h3C, 1'b0, 1'b0, 64'h30C, 64'h0); cyc(); cyc();

    // Stall for three cycles in DONE
    drive(4'd11, rnd64(), rnd64(), 1'b0, 1'b0, 64'h400, 64'h0);
    repeat (65) cyc();
    stall = 1'b1; repeat (3) cyc();
    stall = 1'b0; cyc();
    drive(4'd5, 64'hAA, 64'h55, 1'b0, 1'b0, 64'h404, 64'h0); cyc();

    // Reset asserted at BUSY step 30
    drive(4'd11, rnd64(), rnd64(), 1'b0, 1'b0, 64'h500, 64'h0);
    repeat (31) cyc();
    reset = 1'b0; cyc(); cyc();
    reset = 1'b1;
    drive(4'd0, 64'd10, 64'd20, 1'b0, 1'b0, 64'h504, 64'h0); cyc(); cyc();

    // Randomized traffic; EXB fields are held while the model is mid-multiply
    for (int i = 0; i < 600; i++) begin
      if (m_mode == M_IDLE) begin
        drive(($urandom_range(0, 5) == 0) ? 4'd11 : 4'($urandom), rnd64(), rnd64(),
              1'($urandom), 1'($urandom), rnd64(), rnd64());
      end
      stall = ($urandom_range(0, 7) == 0);
      flush = ($urandom_range(0, 15) == 0);
      reset = ($urandom_range(0, 199) != 0);
      cyc();
    end
    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    drive(4'd0, 64'd1, 64'd2, 1'b0, 1'b0, 64'h0, 64'h0);
    cyc();

    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      checks++;
      $display("FAIL scoreboard_drain left=%0d exp=0", sb.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
